// File: rtl/cond_issue_ctrl.sv
// Issue-stage controller: evaluates instruction condition codes against the CPSR flags,
// tracks in-flight flag writers, and feeds execute through a one-entry valid/ready slot.
module cond_issue_ctrl #(
    parameter int MAX_PEND = 3,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_ir,
    output logic              in_ready,
    output logic              ex_valid,
    output logic [31:0]       ex_ir,
    output logic              ex_exec,
    output logic              ex_setf,
    output logic              ex_undef,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              fl_we,
    input  logic [3:0]        fl_in,
    output logic [3:0]        flags,
    output logic [PEND_W-1:0] pend
);

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

    // Flag layout is {C,N,V,Z}.
    function automatic logic cond_pass(input cond_e cond, input logic [3:0] f);
        logic c, n, v, z;
        {c, n, v, z} = f;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c & !z;
            COND_LS: cond_pass = !c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    slot_e             slot_q, slot_d;
    logic [31:0]       ir_q, ir_d;
    logic              exec_q, exec_d;
    logic              setf_q, setf_d;
    logic              undef_q, undef_d;
    logic [3:0]        flags_q, flags_d;
    logic [PEND_W-1:0] pend_q, pend_d;

    logic  slot_full;
    logic  sat_hold;
    logic  take;
    logic  slot_free;
    logic  flag_busy;
    logic  accept;
    logic  inc;
    logic  dec;
    logic  new_exec;
    cond_e in_cond;

    assign slot_full = (slot_q == SLOT_FULL);
    assign in_cond   = cond_e'(in_ir[31:28]);

    // A flag-setting slot may not leave while the counter is full, unless a writeback frees an entry.
    assign sat_hold  = setf_q & (pend_q == PEND_W'(MAX_PEND)) & !fl_we;
    assign take      = slot_full & ex_ready & !sat_hold;
    assign slot_free = !slot_full | take;
    assign flag_busy = (pend_q != '0) | (slot_full & setf_q & !flush);
    assign in_ready  = slot_free & !flush & ((in_cond == COND_AL) | !flag_busy);
    assign accept    = in_valid & in_ready;
    assign inc       = take & setf_q & !flush;
    assign dec       = fl_we & (pend_q != '0);
    assign new_exec  = cond_pass(in_cond, flags_q);

    // NOTE: every _d gets a default first so this block cannot infer a latch.
    always_comb begin
        slot_d  = slot_q;
        ir_d    = ir_q;
        exec_d  = exec_q;
        setf_d  = setf_q;
        undef_d = undef_q;
        flags_d = fl_we ? fl_in : flags_q;
        pend_d  = pend_q;

        if (inc && !dec) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_W'(1);
        end

        if (flush) begin
            slot_d = SLOT_EMPTY;
        end else if (accept) begin
            slot_d  = SLOT_FULL;
            ir_d    = in_ir;
            exec_d  = new_exec;
            setf_d  = new_exec & (in_ir[27:26] == 2'b00) & in_ir[20];
            undef_d = (in_cond == COND_NV);
        end else if (take) begin
            slot_d = SLOT_EMPTY;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q  <= SLOT_EMPTY;
            ir_q    <= '0;
            exec_q  <= 1'b0;
            setf_q  <= 1'b0;
            undef_q <= 1'b0;
            flags_q <= '0;
            pend_q  <= '0;
        end else begin
            slot_q  <= slot_d;
            ir_q    <= ir_d;
            exec_q  <= exec_d;
            setf_q  <= setf_d;
            undef_q <= undef_d;
            flags_q <= flags_d;
            pend_q  <= pend_d;
        end
    end

    assign ex_valid = slot_full;
    assign ex_ir    = ir_q;
    assign ex_exec  = exec_q;
    assign ex_setf  = setf_q;
    assign ex_undef = undef_q;
    assign flags    = flags_q;
    assign pend     = pend_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Self-checking bench for cond_issue_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the issue rules.
module tb_cond_issue_ctrl;

    localparam int MAX_PEND = 3;
    localparam int PEND_W   = 2;

    localparam logic [27:0] MOV_BODY  = 28'h1A0_0000;
    localparam logic [27:0] ADDS_BODY = 28'h090_0001;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [31:0]       in_ir;
    logic              in_ready;
    logic              ex_valid;
    logic [31:0]       ex_ir;
    logic              ex_exec;
    logic              ex_setf;
    logic              ex_undef;
    logic              ex_ready;
    logic              flush;
    logic              fl_we;
    logic [3:0]        fl_in;
    logic [3:0]        flags;
    logic [PEND_W-1:0] pend;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit       m_valid;
    bit [31:0] m_ir;
    bit       m_exec;
    bit       m_setf;
    bit       m_undef;
    bit [3:0] m_flags;
    int       m_pend;

    cond_issue_ctrl #(.MAX_PEND(MAX_PEND), .PEND_W(PEND_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(in_ir), .in_ready(in_ready),
        .ex_valid(ex_valid), .ex_ir(ex_ir), .ex_exec(ex_exec), .ex_setf(ex_setf),
        .ex_undef(ex_undef), .ex_ready(ex_ready), .flush(flush), .fl_we(fl_we),
        .fl_in(fl_in), .flags(flags), .pend(pend)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic bit m_cond(input bit [3:0] cond, input bit [3:0] f);
        bit c = f[3];
        bit n = f[2];
        bit v = f[1];
        bit z = f[0];
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle();
        in_valid = 1'b0;
        in_ir    = '0;
        ex_ready = 1'b0;
        flush    = 1'b0;
        fl_we    = 1'b0;
        fl_in    = '0;
    endtask

    task automatic model_reset();
        m_valid = 0; m_ir = '0; m_exec = 0; m_setf = 0; m_undef = 0;
        m_flags = '0; m_pend = 0;
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check registered outputs after the edge.
    task automatic tick();
        bit busy, blocked, taken, rdy, acc, inc, dec, ex;
        bit n_valid, n_exec, n_setf, n_undef;
        bit [31:0] n_ir;
        bit [3:0]  cond;
        int n_pend;

        @(negedge clk);
        cond    = in_ir[31:28];
        busy    = (m_pend > 0) || (m_valid && m_setf && !flush);
        blocked = m_setf && (m_pend == MAX_PEND) && !fl_we;
        taken   = m_valid && ex_ready && !blocked;
        rdy     = (!m_valid || taken) && !flush && (cond == 4'hE || !busy);
        acc     = in_valid && rdy;
        inc     = taken && m_setf && !flush;
        dec     = fl_we && (m_pend > 0);

        checks++;
        if (in_ready !== rdy) begin
            errors++;
            $display("FAIL in_ready @%0t: got %0b expected %0b", $time, in_ready, rdy);
        end

        n_pend  = m_pend + int'(inc) - int'(dec);
        n_valid = m_valid; n_ir = m_ir; n_exec = m_exec; n_setf = m_setf; n_undef = m_undef;
        if (flush) begin
            n_valid = 0;
        end else if (acc) begin
            ex      = m_cond(cond, m_flags);
            n_valid = 1;
            n_ir    = in_ir;
            n_exec  = ex;
            n_setf  = ex && (in_ir[27:26] == 2'b00) && in_ir[20];
            n_undef = (cond == 4'hF);
        end else if (taken) begin
            n_valid = 0;
        end
        if (fl_we) m_flags = fl_in;
        m_pend = n_pend;
        m_valid = n_valid; m_ir = n_ir; m_exec = n_exec; m_setf = n_setf; m_undef = n_undef;

        @(posedge clk);
        #1;
        checks++;
        if (ex_valid !== m_valid) begin
            errors++;
            $display("FAIL ex_valid @%0t: got %0b expected %0b", $time, ex_valid, m_valid);
        end
        checks++;
        if (flags !== m_flags) begin
            errors++;
            $display("FAIL flags @%0t: got %h expected %h", $time, flags, m_flags);
        end
        checks++;
        if (int'(pend) != m_pend || $isunknown(pend)) begin
            errors++;
            $display("FAIL pend @%0t: got %0d expected %0d", $time, pend, m_pend);
        end
        if (m_valid) begin
            checks++;
            if (ex_ir !== m_ir || ex_exec !== m_exec || ex_setf !== m_setf || ex_undef !== m_undef) begin
                errors++;
                $display("FAIL slot @%0t: got ir=%h exec=%0b setf=%0b undef=%0b expected ir=%h exec=%0b setf=%0b undef=%0b",
                         $time, ex_ir, ex_exec, ex_setf, ex_undef, m_ir, m_exec, m_setf, m_undef);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ex_valid !== 1'b0 || flags !== 4'h0 || pend !== '0 || ex_ir !== 32'h0 ||
            ex_exec !== 1'b0 || ex_setf !== 1'b0 || ex_undef !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b flags=%h pend=%0d ir=%h expected all zero",
                     ex_valid, flags, pend, ex_ir);
        end

        in_valid = 1; in_ir = {4'hE, ADDS_BODY}; fl_we = 1; fl_in = 4'hF;
        tick();
        fl_we = 0; in_ir = {4'hE, MOV_BODY}; ex_ready = 1;
        tick();
        idle();
        checks++;
        if (ex_valid !== 1'b1 || pend !== 2'd1 || flags !== 4'hF) begin
            errors++;
            $display("FAIL pre_reset: got valid=%0b pend=%0d flags=%h expected 1/1/f", ex_valid, pend, flags);
        end

        #2 reset = 1;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || flags !== 4'h0 || pend !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b flags=%h pend=%0d expected 0/0/0", ex_valid, flags, pend);
        end
        model_reset();
        @(posedge clk);
        #1 reset = 0;

        fl_we = 1; fl_in = 4'h0;
        tick();
        idle();
    endtask

    task automatic test_cond_table();
        bit [3:0] conds [6] = '{4'h0, 4'h1, 4'h9, 4'hC, 4'hD, 4'hF};
        bit       exp_x [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        fl_we = 1; fl_in = 4'b0001;
        tick();
        idle();
        ex_ready = 1; in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            in_ir = {conds[i], MOV_BODY};
            tick();
            checks++;
            if (ex_exec !== exp_x[i] || ex_undef !== (i == 5)) begin
                errors++;
                $display("FAIL cond_%h: got exec=%0b undef=%0b expected exec=%0b undef=%0b",
                         conds[i], ex_exec, ex_undef, exp_x[i], (i == 5));
            end
        end
        in_valid = 0;
        tick();
        idle();
    endtask

    task automatic test_flag_hazard();
        fl_we = 1; fl_in = 4'b0000;
        tick();
        idle();
        ex_ready = 1; in_valid = 1; in_ir = 32'hE090_0001;
        tick();
        in_ir = {4'h0, MOV_BODY};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hazard_wait_%0d: in_ready=%0b expected 0", i, in_ready);
            end
            fl_we = (i == 3); fl_in = 4'b0001;
            tick();
        end
        fl_we = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hazard_release: in_ready=%0b expected 1", in_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_exec !== 1'b1 || ex_ir !== {4'h0, MOV_BODY}) begin
            errors++;
            $display("FAIL hazard_eq_issue: got valid=%0b exec=%0b ir=%h expected 1/1/%h",
                     ex_valid, ex_exec, ex_ir, {4'h0, MOV_BODY});
        end
        in_valid = 0;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        ex_ready = 1; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_ir = {4'hE, MOV_BODY} | 32'(i + 1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: in_ready=%0b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (ex_valid !== 1'b1 || ex_ir !== ({4'hE, MOV_BODY} | 32'(i + 1)) || pend !== '0) begin
                errors++;
                $display("FAIL b2b_issue_%0d: got valid=%0b ir=%h pend=%0d expected 1/%h/0",
                         i, ex_valid, ex_ir, pend, {4'hE, MOV_BODY} | 32'(i + 1));
            end
        end
        in_valid = 0;
        tick();
        idle();
    endtask

    task automatic test_backpressure_flush();
        in_valid = 1; in_ir = {4'hE, ADDS_BODY};
        tick();
        in_ir = {4'hE, MOV_BODY};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_%0d: in_ready=%0b expected 0", i, in_ready);
            end
            tick();
            checks++;
            if (ex_valid !== 1'b1 || ex_ir !== {4'hE, ADDS_BODY}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%0b ir=%h expected 1/%h", i, ex_valid, ex_ir, {4'hE, ADDS_BODY});
            end
        end
        flush = 1; ex_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%0b expected 0", in_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || pend !== '0) begin
            errors++;
            $display("FAIL flush_drop: got valid=%0b pend=%0d expected 0/0", ex_valid, pend);
        end
        idle();
    endtask

    task automatic test_saturation();
        ex_ready = 1; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_ir = {4'hE, ADDS_BODY} | 32'(i << 12);
            tick();
        end
        in_valid = 0;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_ir !== ({4'hE, ADDS_BODY} | 32'(3 << 12)) || pend !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold: got valid=%0b ir=%h pend=%0d expected 1/%h/3",
                     ex_valid, ex_ir, pend, {4'hE, ADDS_BODY} | 32'(3 << 12));
        end
        fl_we = 1; fl_in = 4'h2;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || pend !== 2'd3) begin
            errors++;
            $display("FAIL sat_inc_dec: got valid=%0b pend=%0d expected 0/3", ex_valid, pend);
        end
        ex_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        bit [31:0] body;
        bit [3:0]  cond;
        for (int n = 0; n < 600; n++) begin
            cond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            body = $urandom;
            if ($urandom_range(0, 1) == 1) body[27:26] = 2'b00;
            in_valid = ($urandom_range(0, 3) != 0);
            in_ir    = {cond, body[27:0]};
            ex_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 9) == 0);
            fl_we    = (m_pend > 0) && ($urandom_range(0, 4) == 0);
            fl_in    = 4'($urandom_range(0, 15));
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        test_reset();
        test_cond_table();
        test_flag_hazard();
        test_back_to_back();
        test_backpressure_flush();
        test_saturation();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
